// File: rtl/booth_pkg.sv
// booth_pkg: action codes, FSM states and datapath widths shared by the Booth MAC.
package booth_pkg;
  localparam int PROD_W = 16;
  localparam int PP_W = 10;
  localparam logic [2:0] ACT_ZERO = 3'd0;
  localparam logic [2:0] ACT_PM = 3'd1;
  localparam logic [2:0] ACT_P2M = 3'd2;
  localparam logic [2:0] ACT_NM = 3'd3;
  localparam logic [2:0] ACT_N2M = 3'd4;
  localparam logic [2:0] ACT_ZERO7 = 3'd7;
  typedef enum logic [1:0] {IDLE, CALC, ACCUM, DONE} state_t;
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a radix-4 Booth digit {q[2i+1],q[2i],q[2i-1]} to an action code.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] digit,
  output logic [2:0] act
);
  always_comb
    act = (digit == 3'b001 || digit == 3'b010) ? ACT_PM :
          (digit == 3'b011) ? ACT_P2M :
          (digit == 3'b100) ? ACT_N2M :
          (digit == 3'b101 || digit == 3'b110) ? ACT_NM : ACT_ZERO;
endmodule

// File: rtl/booth_mac_seq.sv
// booth_mac_seq: sequential radix-4 Booth 8x8 signed multiply-accumulate; SATURATE_EN selects saturating accumulation.
module booth_mac_seq
  import booth_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       multiplicand,
  input  logic [7:0]       multiplier,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);
  state_t state, state_n;
  logic [7:0] m, q;
  logic clr;
  logic [1:0] i;
  logic [PROD_W-1:0] prod, pp_sh;
  logic [ACC_W-1:0] acc, acc_n, prod_x;
  logic [ACC_W:0] sum;
  logic [8:0] qx;
  logic [2:0] act;
  logic [PP_W-1:0] m1, m2, pp;
  assign qx = {q, 1'b0};
  booth_r4_encoder u_enc (.digit(qx[{i, 1'b0} +: 3]), .act(act));
  assign m1 = {{(PP_W-8){m[7]}}, m};
  assign m2 = m1 << 1;
  assign pp = (act == ACT_PM) ? m1 :
              (act == ACT_P2M) ? m2 :
              (act == ACT_NM) ? -m1 :
              (act == ACT_N2M) ? -m2 : '0;
  assign pp_sh = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp} << {i, 1'b0};
  assign prod_x = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};
`ifdef SATURATE_EN
  // sign bits disagree only on signed overflow; clamp toward the overflow direction
  assign acc_n = (sum[ACC_W] != sum[ACC_W-1]) ?
                 (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                 sum[ACC_W-1:0];
`else
  assign acc_n = sum[ACC_W-1:0];
`endif
  always_comb
    state_n = (state == IDLE) ? (in_valid ? CALC : IDLE) :
              (state == CALC) ? ((i == 2'd3) ? ACCUM : CALC) :
              (state == ACCUM) ? DONE :
              (out_ready ? IDLE : DONE);
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy = (state != IDLE);
  assign result = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m <= '0;
      q <= '0;
      clr <= 1'b0;
      i <= '0;
      prod <= '0;
      acc <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        m <= multiplicand;
        q <= multiplier;
        clr <= acc_clear;
        prod <= '0;
        i <= '0;
      end
      if (state == CALC) begin
        prod <= prod + pp_sh;
        i <= i + 2'd1;
      end
      if (state == ACCUM) acc <= clr ? prod_x : acc_n;
    end
  end
endmodule
